segment_reader: RTL and testbench

SEGMENT_READER -- requirements
Module: segment_reader

---
 rtl/segment_reader_if.sv | 33 +++
 rtl/segment_reader.sv | 149 ++++++++++++++
 tb/tb_segment_reader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/segment_reader_if.sv
// Bundle of the observed 7-segment drive and the decoded results.
//   segment     : observed drive {g,f,e,d,c,b,a}, 1 = lit
//   digit       : last accepted legal digit (0..9)
//   digit_valid : last accepted pattern is a legal digit
//   new_digit   : one-cycle pulse on acceptance of a new legal digit
//   up_pulse / down_pulse / jump_pulse : one-cycle step classification
//   bad_pattern : last accepted pattern is illegal
//   up_count / down_count : saturating event counts
// slave is the reader side, master is the side that drives segment.
interface segment_reader_if;
  logic [6:0] segment;
  logic [3:0] digit;
  logic       digit_valid;
  logic       new_digit;
  logic       up_pulse;
  logic       down_pulse;
  logic       jump_pulse;
  logic       bad_pattern;
  logic [7:0] up_count;
  logic [7:0] down_count;

  modport master (
    output segment,
    input  digit, digit_valid, new_digit, up_pulse, down_pulse, jump_pulse,
    input  bad_pattern, up_count, down_count
  );

  modport slave (
    input  segment,
    output digit, digit_valid, new_digit, up_pulse, down_pulse, jump_pulse,
    output bad_pattern, up_count, down_count
  );
endinterface

// File: rtl/segment_reader.sv
// Debounces an observed 7-segment drive and decodes it into a digit, with
// step classification (up / down / jump) and saturating up/down event counts.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : segment_reader_if.slave (segment in; decoded results out)
module segment_reader #(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  segment_reader_if.slave bus
);

  localparam logic [3:0] StableCnt = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {StInit, StTrack, StBad} state_e;

  state_e     state_q, state_d;
  logic [6:0] sample_q;
  logic [3:0] run_q, run_d;
  logic [6:0] acc_q, acc_d;
  logic [3:0] digit_q, digit_d;
  logic       new_q, new_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic       jump_q, jump_d;
  logic [7:0] up_cnt_q, up_cnt_d;
  logic [7:0] dn_cnt_q, dn_cnt_d;

  logic       same;
  logic       reach;
  logic       accept;
  logic       legal;
  logic [3:0] dec;
  logic [3:0] nxt_digit;
  logic [3:0] prv_digit;

  always_comb begin
    legal = 1'b1;
    dec   = 4'd0;
    unique case (bus.segment)
      7'h3F: dec = 4'd0;
      7'h06: dec = 4'd1;
      7'h5B: dec = 4'd2;
      7'h4F: dec = 4'd3;
      7'h66: dec = 4'd4;
      7'h6D: dec = 4'd5;
      7'h7D: dec = 4'd6;
      7'h07: dec = 4'd7;
      7'h7F: dec = 4'd8;
      7'h6F: dec = 4'd9;
      default: legal = 1'b0;
    endcase
  end

  assign same = (bus.segment == sample_q);

  always_comb begin
    run_d = run_q;
    if (!same) begin
      run_d = 4'd1;
    end else if (run_q < StableCnt) begin
      run_d = run_q + 4'd1;
    end
  end

  // Reaching the threshold happens once per run: a saturated counter on an
  // unchanged sample is not a fresh arrival.
  assign reach  = (run_d == StableCnt) && !(same && (run_q == StableCnt));
  assign accept = reach && ((state_q == StInit) || (bus.segment != acc_q));

  assign nxt_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
  assign prv_digit = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    digit_d  = digit_q;
    new_d    = 1'b0;
    up_d     = 1'b0;
    down_d   = 1'b0;
    jump_d   = 1'b0;
    up_cnt_d = up_cnt_q;
    dn_cnt_d = dn_cnt_q;
    if (accept) begin
      acc_d = bus.segment;
      if (!legal) begin
        state_d = StBad;
      end else begin
        state_d = StTrack;
        digit_d = dec;
        new_d   = 1'b1;
        unique case (state_q)
          StTrack: begin
            if (dec == nxt_digit) begin
              up_d = 1'b1;
            end else if (dec == prv_digit) begin
              down_d = 1'b1;
            end else begin
              jump_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
    if (up_d && (up_cnt_q != 8'hFF)) up_cnt_d = up_cnt_q + 8'd1;
    if (down_d && (dn_cnt_q != 8'hFF)) dn_cnt_d = dn_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StInit;
      sample_q <= 7'h00;
      run_q    <= 4'd0;
      acc_q    <= 7'h00;
      digit_q  <= 4'd0;
      new_q    <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      jump_q   <= 1'b0;
      up_cnt_q <= 8'd0;
      dn_cnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      sample_q <= bus.segment;
      run_q    <= run_d;
      acc_q    <= acc_d;
      digit_q  <= digit_d;
      new_q    <= new_d;
      up_q     <= up_d;
      down_q   <= down_d;
      jump_q   <= jump_d;
      up_cnt_q <= up_cnt_d;
      dn_cnt_q <= dn_cnt_d;
    end
  end

  assign bus.digit       = digit_q;
  assign bus.digit_valid = (state_q == StTrack);
  assign bus.bad_pattern = (state_q == StBad);
  assign bus.new_digit   = new_q;
  assign bus.up_pulse    = up_q;
  assign bus.down_pulse  = down_q;
  assign bus.jump_pulse  = jump_q;
  assign bus.up_count    = up_cnt_q;
  assign bus.down_count  = dn_cnt_q;

endmodule

// File: tb/tb_segment_reader.sv
module tb_segment_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  segment_reader_if bus ();

  segment_reader #(.STABLE_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pulses();
    return {bus.new_digit, bus.up_pulse, bus.down_pulse, bus.jump_pulse};
  endfunction

  // Drive one value across one rising edge; returns 1 time unit after the edge.
  task automatic step(input logic [6:0] v);
    bus.segment = v;
    @(posedge clk);
    #1;
  endtask

  task automatic hold2(input logic [6:0] v);
    step(v);
    step(v);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.segment = 7'h00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.digit, bus.digit_valid, bus.bad_pattern, pulses(), bus.up_count, bus.down_count}
        !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got digit=%0d valid=%b bad=%b pulses=%b up=%0d dn=%0d exp all 0",
               bus.digit, bus.digit_valid, bus.bad_pattern, pulses(), bus.up_count,
               bus.down_count);
    end
  endtask

  task automatic test_first_accept();
    rst = 1'b0;
    step(7'h3F);
    n_checks++;
    if ({bus.new_digit, bus.digit_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL first_early got new=%b valid=%b exp 0 0", bus.new_digit, bus.digit_valid);
    end
    step(7'h3F);
    n_checks++;
    if (pulses() !== 4'b1000 || bus.digit !== 4'd0 || bus.digit_valid !== 1'b1 ||
        bus.up_count !== 8'd0 || bus.down_count !== 8'd0) begin
      n_fail++;
      $display("FAIL first_accept got pulses=%b digit=%0d valid=%b up=%0d dn=%0d exp 1000 0 1 0 0",
               pulses(), bus.digit, bus.digit_valid, bus.up_count, bus.down_count);
    end
    step(7'h3F);
    n_checks++;
    if (pulses() !== 4'b0000) begin
      n_fail++;
      $display("FAIL first_pulse_width got pulses=%b exp 0000", pulses());
    end
  endtask

  task automatic test_steps();
    logic [6:0] pat [4] = '{7'h06, 7'h3F, 7'h6F, 7'h3F};
    logic [3:0] exp_p [4] = '{4'b1100, 4'b1010, 4'b1010, 4'b1100};
    logic [3:0] exp_d [4] = '{4'd1, 4'd0, 4'd9, 4'd0};
    logic [7:0] exp_u [4] = '{8'd1, 8'd1, 8'd1, 8'd2};
    logic [7:0] exp_n [4] = '{8'd0, 8'd1, 8'd2, 8'd2};
    for (int i = 0; i < 4; i++) begin
      hold2(pat[i]);
      n_checks++;
      if (pulses() !== exp_p[i] || bus.digit !== exp_d[i] || bus.up_count !== exp_u[i] ||
          bus.down_count !== exp_n[i]) begin
        n_fail++;
        $display("FAIL step_%0d got pulses=%b digit=%0d up=%0d dn=%0d exp %b %0d %0d %0d", i,
                 pulses(), bus.digit, bus.up_count, bus.down_count, exp_p[i], exp_d[i],
                 exp_u[i], exp_n[i]);
      end
    end
  endtask

  task automatic test_glitch();
    logic [6:0] seq [4] = '{7'h00, 7'h3F, 7'h3F, 7'h3F};
    for (int i = 0; i < 4; i++) begin
      step(seq[i]);
      n_checks++;
      if (pulses() !== 4'b0000 || bus.digit !== 4'd0 || bus.digit_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL glitch_%0d got pulses=%b digit=%0d valid=%b exp 0000 0 1", i, pulses(),
                 bus.digit, bus.digit_valid);
      end
    end
    hold2(7'h5B);
    n_checks++;
    if (pulses() !== 4'b1001 || bus.digit !== 4'd2) begin
      n_fail++;
      $display("FAIL jump got pulses=%b digit=%0d exp 1001 2", pulses(), bus.digit);
    end
  endtask

  task automatic test_bad();
    hold2(7'h00);
    n_checks++;
    if (pulses() !== 4'b0000 || bus.bad_pattern !== 1'b1 || bus.digit_valid !== 1'b0 ||
        bus.digit !== 4'd2) begin
      n_fail++;
      $display("FAIL bad_enter got pulses=%b bad=%b valid=%b digit=%0d exp 0000 1 0 2",
               pulses(), bus.bad_pattern, bus.digit_valid, bus.digit);
    end
    hold2(7'h08);
    n_checks++;
    if (pulses() !== 4'b0000 || bus.bad_pattern !== 1'b1 || bus.digit !== 4'd2) begin
      n_fail++;
      $display("FAIL bad_to_bad got pulses=%b bad=%b digit=%0d exp 0000 1 2", pulses(),
               bus.bad_pattern, bus.digit);
    end
    hold2(7'h4F);
    n_checks++;
    if (pulses() !== 4'b1000 || bus.digit !== 4'd3 || bus.bad_pattern !== 1'b0 ||
        bus.digit_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_recover got pulses=%b digit=%0d bad=%b valid=%b exp 1000 3 0 1",
               pulses(), bus.digit, bus.bad_pattern, bus.digit_valid);
    end
  endtask

  task automatic test_mid_reset();
    step(7'h06);
    rst = 1'b1;
    #2;
    n_checks++;
    if ({bus.digit, bus.digit_valid, bus.bad_pattern, pulses(), bus.up_count, bus.down_count}
        !== 26'd0) begin
      n_fail++;
      $display("FAIL async_reset got digit=%0d valid=%b pulses=%b up=%0d dn=%0d exp all 0",
               bus.digit, bus.digit_valid, pulses(), bus.up_count, bus.down_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(7'h06);
    n_checks++;
    if (pulses() !== 4'b0000 || bus.digit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_partial got pulses=%b valid=%b exp 0000 0", pulses(),
               bus.digit_valid);
    end
    step(7'h06);
    n_checks++;
    if (pulses() !== 4'b1000 || bus.digit !== 4'd1 || bus.digit_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_reaccept got pulses=%b digit=%0d valid=%b exp 1000 1 1", pulses(),
               bus.digit, bus.digit_valid);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_c;
    for (int i = 0; i < 260; i++) begin
      exp_c = (i >= 254) ? 8'd255 : 8'(i + 1);
      hold2(7'h3F);
      n_checks++;
      if (bus.down_pulse !== 1'b1 || bus.down_count !== exp_c) begin
        n_fail++;
        $display("FAIL sat_down_%0d got pulse=%b count=%0d exp 1 %0d", i, bus.down_pulse,
                 bus.down_count, exp_c);
      end
      hold2(7'h06);
      n_checks++;
      if (bus.up_pulse !== 1'b1 || bus.up_count !== exp_c) begin
        n_fail++;
        $display("FAIL sat_up_%0d got pulse=%b count=%0d exp 1 %0d", i, bus.up_pulse,
                 bus.up_count, exp_c);
      end
    end
  endtask

  initial begin
    bus.segment = 7'h00;
    test_reset();
    test_first_accept();
    test_steps();
    test_glitch();
    test_bad();
    test_mid_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
